// File: rtl/io_sequencer.sv
// Operand/opcode entry sequencer: debounced Enter/Clear buttons step through
// GET_A -> GET_B -> GET_OP -> RUN -> SHOW. Optional RUN timeout via IO_SEQ_TIMEOUT_EN.
module io_sequencer #(
   parameter int unsigned DEBOUNCE_TICKS = 20,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       Tick,
   input  logic [3:0] Slide_Switch,
   input  logic [3:0] Button,
   input  logic [7:0] Result,
   input  logic       Done,
   output logic [3:0] User_Input0,
   output logic [3:0] User_Input1,
   output logic [1:0] Opcode,
   output logic       Start,
   output logic [7:0] Display,
   output logic [3:0] LED,
   output logic       Error
);

   typedef enum logic [2:0] {GET_A, GET_B, GET_OP, RUN, SHOW} state_t;

   state_t          state;
   logic [1:0]      sync1, sync2, deb, deb_d;
   logic [1:0][7:0] cnt;
   logic            enter_evt, clear_evt;
   logic            unused_ok;

`ifdef IO_SEQ_TIMEOUT_EN
   logic [31:0] tcnt;
   assign unused_ok = ^Button[3:2];
`else
   assign Error     = 1'b0;
   assign unused_ok = ^{Button[3:2], 1'(TIMEOUT_CYCLES)};
`endif

   function automatic logic [3:0] led_code(input state_t s);
      case (s)
         GET_A:   led_code = 4'b0001;
         GET_B:   led_code = 4'b0010;
         GET_OP:  led_code = 4'b0100;
         RUN:     led_code = 4'b1000;
         SHOW:    led_code = 4'b1001;
         default: led_code = 4'b0001;
      endcase
   endfunction

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= Button[1:0];
         sync2 <= sync1;
      end
   end

   // Counter counts consecutive mismatching Tick samples; any matching sample restarts it.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         deb   <= '0;
         deb_d <= '0;
         cnt   <= '0;
      end else begin
         deb_d <= deb;
         if (Tick) begin
            for (int unsigned i = 0; i < 2; i++) begin
               if (sync2[i] != deb[i]) begin
                  if (cnt[i] == 8'(DEBOUNCE_TICKS - 1)) begin
                     deb[i] <= sync2[i];
                     cnt[i] <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + 8'd1;
                  end
               end else begin
                  cnt[i] <= '0;
               end
            end
         end
      end
   end

   assign enter_evt = deb[0] & ~deb_d[0];
   assign clear_evt = deb[1] & ~deb_d[1];

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state       <= GET_A;
         LED         <= 4'b0001;
         User_Input0 <= '0;
         User_Input1 <= '0;
         Opcode      <= '0;
         Start       <= 1'b0;
         Display     <= '0;
`ifdef IO_SEQ_TIMEOUT_EN
         Error       <= 1'b0;
         tcnt        <= '0;
`endif
      end else begin
         Start <= 1'b0;
         if (clear_evt) begin
            state       <= GET_A;
            LED         <= led_code(GET_A);
            User_Input0 <= '0;
            User_Input1 <= '0;
            Opcode      <= '0;
            Display     <= '0;
`ifdef IO_SEQ_TIMEOUT_EN
            Error       <= 1'b0;
`endif
         end else begin
            case (state)
               GET_A: begin
                  Display <= {4'h0, Slide_Switch};
                  if (enter_evt) begin
                     User_Input0 <= Slide_Switch;
                     state       <= GET_B;
                     LED         <= led_code(GET_B);
                  end
               end
               GET_B: begin
                  Display <= {4'h0, Slide_Switch};
                  if (enter_evt) begin
                     User_Input1 <= Slide_Switch;
                     state       <= GET_OP;
                     LED         <= led_code(GET_OP);
                  end
               end
               GET_OP: begin
                  Display <= {4'h0, Slide_Switch};
                  if (enter_evt) begin
                     Opcode <= Slide_Switch[1:0];
                     Start  <= 1'b1;
                     state  <= RUN;
                     LED    <= led_code(RUN);
`ifdef IO_SEQ_TIMEOUT_EN
                     tcnt   <= '0;
`endif
                  end
               end
               RUN: begin
`ifdef IO_SEQ_TIMEOUT_EN
                  tcnt <= tcnt + 32'd1;
`endif
                  // Start is high only in the first RUN cycle, so it masks Done there.
                  if (!Start && Done) begin
                     Display <= Result;
                     state   <= SHOW;
                     LED     <= led_code(SHOW);
                  end
`ifdef IO_SEQ_TIMEOUT_EN
                  else if (tcnt == 32'(TIMEOUT_CYCLES - 1)) begin
                     Display <= 8'hEE;
                     Error   <= 1'b1;
                     state   <= SHOW;
                     LED     <= led_code(SHOW);
                  end
`endif
               end
               SHOW: begin
                  if (enter_evt) begin
                     state <= GET_A;
                     LED   <= led_code(GET_A);
`ifdef IO_SEQ_TIMEOUT_EN
                     Error <= 1'b0;
`endif
                  end
               end
               default: begin
                  state <= GET_A;
                  LED   <= led_code(GET_A);
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_io_sequencer.sv
// Directed bench for io_sequencer with DEBOUNCE_TICKS=4 and a Tick every 4 clocks.
module tb_io_sequencer;

   logic       CLK, Reset, Tick, Done;
   logic [3:0] Slide_Switch, Button;
   logic [7:0] Result;
   logic [3:0] User_Input0, User_Input1, LED;
   logic [1:0] Opcode;
   logic       Start, Error;
   logic [7:0] Display;

   int         tests = 0;
   int         fails = 0;
   int         start_cnt = 0;
   int         show_cnt = 0;
   logic [7:0] sb_q[$];

   io_sequencer #(.DEBOUNCE_TICKS(4), .TIMEOUT_CYCLES(10)) dut (
      .CLK(CLK), .Reset(Reset), .Tick(Tick), .Slide_Switch(Slide_Switch),
      .Button(Button), .Result(Result), .Done(Done),
      .User_Input0(User_Input0), .User_Input1(User_Input1), .Opcode(Opcode),
      .Start(Start), .Display(Display), .LED(LED), .Error(Error)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      int div = 0;
      Tick = 1'b0;
      forever begin
         @(negedge CLK);
         div  = (div + 1) % 4;
         Tick = (div == 0);
      end
   end

   always @(negedge CLK) begin
      if (Start === 1'b1) start_cnt++;
      if (LED === 4'b1001) show_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic press(input logic [3:0] mask);
      Button = mask;
      cycles(28);
      Button = 4'b0000;
      cycles(28);
   endtask

   task automatic wait_led(input logic [3:0] want, input int maxc, input string tag);
      int n = 0;
      while (LED !== want && n < maxc) begin
         @(negedge CLK);
         n++;
      end
      check(tag, LED, want);
   endtask

   task automatic wait_start(input int maxc, input string tag);
      int n = 0;
      while (Start !== 1'b1 && n < maxc) begin
         @(negedge CLK);
         n++;
      end
      check(tag, Start, 1);
   endtask

   task automatic sb_check(input string tag);
      if (sb_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
      else check(tag, Display, sb_q.pop_front());
   endtask

   initial begin
      int s0, sh0;
      Reset = 1'b1; Button = '0; Done = 1'b0; Result = '0; Slide_Switch = '0;
      #2 Reset = 1'b0;
      @(negedge CLK);
      check("rst_led", LED, 4'b0001);
      check("rst_ops", {User_Input0, User_Input1, Opcode}, 0);
      check("rst_out", {Start, Display, Error}, 0);
      Reset = 1'b1;

      // Basic computation: 3, 5, op 2, Done 3 cycles after Start
      s0 = start_cnt;
      Slide_Switch = 4'd3; press(4'b0001);
      check("a_led", LED, 4'b0010);
      check("a_val", User_Input0, 3);
      check("a_disp", Display, 8'h03);
      Slide_Switch = 4'd5; press(4'b0001);
      check("b_led", LED, 4'b0100);
      check("b_val", User_Input1, 5);
      Slide_Switch = 4'd2; Button = 4'b0001;
      wait_start(40, "op_start");
      check("op_led", LED, 4'b1000);
      check("op_val", Opcode, 2);
      Result = 8'h08; sb_q.push_back(8'h08);
      cycles(3); Done = 1'b1;
      wait_led(4'b1001, 10, "run_show");
      sb_check("run_disp");
      Done = 1'b0; Button = 4'b0000; cycles(28);
      check("one_start", start_cnt - s0, 1);
      check("show_ops", {User_Input0, User_Input1, Opcode}, {4'd3, 4'd5, 2'd2});
      check("err_zero", Error, 0);

      // SHOW + Enter keeps operands
      press(4'b0001);
      check("show_exit", LED, 4'b0001);
      check("keep_ops", {User_Input0, User_Input1, Opcode}, {4'd3, 4'd5, 2'd2});

      // Done outside RUN ignored; Done already high at Start gives 2-cycle latency
      Slide_Switch = 4'd6; press(4'b0001);
      Slide_Switch = 4'd9; press(4'b0001);
      Done = 1'b1; Result = 8'h5A; cycles(6);
      check("done_getop", LED, 4'b0100);
      sb_q.push_back(8'h5A);
      Button = 4'b0001;
      wait_start(40, "lat_start");
      cycles(1);
      check("lat_c1", LED, 4'b1000);
      cycles(1);
      check("lat_c2", LED, 4'b1001);
      sb_check("lat_disp");
      Done = 1'b0; Button = 4'b0000; cycles(28);
      check("lat_ops", {User_Input0, User_Input1, Opcode}, {4'd6, 4'd9, 2'd1});
      press(4'b0001);
      check("lat_exit", LED, 4'b0001);

      // Bouncing Enter: 1 tick, gap, 2 ticks, gap, then stable
      Slide_Switch = 4'd7;
      Button = 4'b0001; cycles(4);
      Button = 4'b0000; cycles(4);
      Button = 4'b0001; cycles(8);
      Button = 4'b0000; cycles(4);
      Button = 4'b0001; cycles(32);
      Button = 4'b0000; cycles(28);
      check("bounce_led", LED, 4'b0010);
      check("bounce_val", User_Input0, 7);

      // Enter and Clear together in GET_B
      press(4'b0011);
      check("both_led", LED, 4'b0001);
      check("both_ops", {User_Input0, User_Input1, Opcode}, 0);

      // Clear in RUN aborts; Enter in RUN ignored; later Done ignored
      Slide_Switch = 4'd1; press(4'b0001);
      Slide_Switch = 4'd4; press(4'b0001);
      Slide_Switch = 4'd1; Button = 4'b0001;
      wait_start(40, "clr_start");
      Button = 4'b0000; cycles(28);
      press(4'b0001);
      check("run_enter", LED, 4'b1000);
      Slide_Switch = 4'd0; press(4'b0010);
      check("clr_led", LED, 4'b0001);
      check("clr_ops", {User_Input0, User_Input1, Opcode}, 0);
      sh0 = show_cnt;
      Done = 1'b1; Result = 8'h77; cycles(10);
      check("clr_done_led", LED, 4'b0001);
      check("clr_disp", Display, 0);
      check("clr_noshow", show_cnt - sh0, 0);
      Done = 1'b0;

      // Reset mid-RUN with Enter held through reset release
      Slide_Switch = 4'd3; press(4'b0001);
      Slide_Switch = 4'd2; press(4'b0001);
      Button = 4'b0001;
      wait_start(40, "rr_start");
      Reset = 1'b0; #1;
      check("rr_led", LED, 4'b0001);
      check("rr_out", {Start, Display, Error, User_Input0, User_Input1, Opcode}, 0);
      @(negedge CLK); Reset = 1'b1; Slide_Switch = 4'd11;
      cycles(8);
      check("held_early", LED, 4'b0001);
      wait_led(4'b0010, 40, "held_press");
      check("held_val", User_Input0, 11);
      Button = 4'b0000; cycles(28);
      check("release_none", LED, 4'b0010);
      Done = 1'b1; cycles(6);
      check("done_getb", LED, 4'b0010);
      Done = 1'b0;

`ifdef IO_SEQ_TIMEOUT_EN
      // Timeout with Done never asserted
      press(4'b0001);
      sb_q.push_back(8'hEE);
      Button = 4'b0001;
      wait_start(40, "to_start");
      wait_led(4'b1001, 30, "to_show");
      sb_check("to_disp");
      check("to_err", Error, 1);
      Button = 4'b0000; cycles(28);
      press(4'b0001);
      check("to_exit", LED, 4'b0001);
      check("to_err_clr", Error, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
